// File: rtl/vending_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : vending_pkg                                                    |
// | Purpose : Types and constants shared between the vending FSM and the     |
// |           change dispenser (payout state encoding, fault codes and coin  |
// |           denominations expressed in 5-unit steps).                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package vending_pkg;

  // Change dispenser payout states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } cd_state_t;

  // Fault codes reported to the vending FSM
  localparam logic [1:0] FC_NONE  = 2'b00;  // no fault
  localparam logic [1:0] FC_SHORT = 2'b01;  // not enough coins to pay exactly
  localparam logic [1:0] FC_JAM   = 2'b10;  // hopper never confirmed a coin

  // Coin values in 5-unit steps
  localparam int DEN_5  = 1;
  localparam int DEN_10 = 2;

endpackage
`default_nettype wire

// File: rtl/coin_inventory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : coin_inventory                                                 |
// | Purpose : Two saturating coin counters (10-coins and 5-coins). Each      |
// |           cycle a counter may be restocked and decremented at once; the  |
// |           result is clamped to [0, 2^CNT_W-1].                           |
// | Ports   : clk, reset        - clock, async active-high reset             |
// |           i_load_valid      - restock strobe                             |
// |           i_load_c10/c5     - coins added on restock                     |
// |           i_dec_10/5        - one coin of that kind has left the hopper  |
// |           o_inv_10/5        - registered inventory                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module coin_inventory #(
  parameter int CNT_W    = 8,
  parameter int INIT_C10 = 0,
  parameter int INIT_C5  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load_valid,
  input  logic [CNT_W-1:0] i_load_c10,
  input  logic [CNT_W-1:0] i_load_c5,
  input  logic             i_dec_10,
  input  logic             i_dec_5,
  output logic [CNT_W-1:0] o_inv_10,
  output logic [CNT_W-1:0] o_inv_5
);

  logic [CNT_W-1:0] r_inv_10;
  logic [CNT_W-1:0] r_inv_5;
  logic [CNT_W-1:0] w_next_10;
  logic [CNT_W-1:0] w_next_5;

  // sat(cur + load - dec): one extra bit holds the carry of the add, the
  // decrement is skipped at zero so the counter can never wrap downwards.
  function automatic logic [CNT_W-1:0] f_next(
    input logic [CNT_W-1:0] cur,
    input logic             load_en,
    input logic [CNT_W-1:0] load,
    input logic             dec
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + (load_en ? {1'b0, load} : '0);
    if (dec && (sum != '0)) begin
      sum = sum - (CNT_W+1)'(1);
    end
    if (sum[CNT_W]) begin
      return '1;
    end
    return sum[CNT_W-1:0];
  endfunction

  assign w_next_10 = f_next(r_inv_10, i_load_valid, i_load_c10, i_dec_10);
  assign w_next_5  = f_next(r_inv_5,  i_load_valid, i_load_c5,  i_dec_5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inv_10 <= CNT_W'(INIT_C10);
      r_inv_5  <= CNT_W'(INIT_C5);
    end else begin
      r_inv_10 <= w_next_10;
      r_inv_5  <= w_next_5;
    end
  end

  assign o_inv_10 = r_inv_10;
  assign o_inv_5  = r_inv_5;

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : change_dispenser                                               |
// | Purpose : Payout side of the vending controller. Pays a change request   |
// |           (in 5-unit steps) greedily with 10- and 5-coins, one coin at a |
// |           time, waiting for the hopper sensor after each ejection.       |
// |           Reports done, shortage (insufficient coins) or jam (timeout).  |
// | Ports   : clk, reset            - clock, async active-high reset         |
// |           i_req_valid/units     - change request and amount              |
// |           o_req_ready           - idle, request can be accepted          |
// |           o_eject_10/5          - single-cycle hopper release pulses     |
// |           i_coin_sensed         - hopper confirms a coin has dropped     |
// |           i_load_valid/c10/c5   - restock                                |
// |           o_busy/done/fault     - status, done/fault are 1-cycle pulses  |
// |           o_fault_code          - last fault, held until next request    |
// |           o_remaining           - unpaid steps of current/last request   |
// |           o_inv_10/5            - coin inventory                         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int INIT_C10    = 0,
  parameter int INIT_C5     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req_valid,
  input  logic [AMT_W-1:0] i_req_units,
  output logic             o_req_ready,
  output logic             o_eject_10,
  output logic             o_eject_5,
  input  logic             i_coin_sensed,
  input  logic             i_load_valid,
  input  logic [CNT_W-1:0] i_load_c10,
  input  logic [CNT_W-1:0] i_load_c5,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fault,
  output logic [1:0]       o_fault_code,
  output logic [AMT_W-1:0] o_remaining,
  output logic [CNT_W-1:0] o_inv_10,
  output logic [CNT_W-1:0] o_inv_5
);

  localparam int               c_TMR_W    = $clog2(ACK_TIMEOUT + 1);
  // WAIT_ACK is entered with the timer at 0, so the last permitted cycle
  // is the one where the timer reads ACK_TIMEOUT-1.
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] c_STEP_10  = AMT_W'(DEN_10);
  localparam logic [AMT_W-1:0] c_STEP_5   = AMT_W'(DEN_5);

  cd_state_t          r_state;
  logic [AMT_W-1:0]   r_remaining;
  logic [1:0]         r_fault_code;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_den_10;     // coin chosen by SELECT: 1 = 10-coin

  logic [CNT_W-1:0]   w_inv_10;
  logic [CNT_W-1:0]   w_inv_5;
  logic               w_ack;
  logic [AMT_W-1:0]   w_rem_next;

  // Sensor pulses only count while a coin is actually in flight
  assign w_ack      = (r_state == ST_WAIT_ACK) && i_coin_sensed;
  assign w_rem_next = r_remaining - (r_den_10 ? c_STEP_10 : c_STEP_5);

  coin_inventory #(
    .CNT_W    (CNT_W),
    .INIT_C10 (INIT_C10),
    .INIT_C5  (INIT_C5)
  ) u_inventory (
    .clk          (clk),
    .reset        (reset),
    .i_load_valid (i_load_valid),
    .i_load_c10   (i_load_c10),
    .i_load_c5    (i_load_c5),
    .i_dec_10     (w_ack && r_den_10),
    .i_dec_5      (w_ack && !r_den_10),
    .o_inv_10     (w_inv_10),
    .o_inv_5      (w_inv_5)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_fault_code <= FC_NONE;
      r_timer      <= '0;
      r_den_10     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_remaining  <= i_req_units;
            r_fault_code <= FC_NONE;
            r_state      <= (i_req_units == '0) ? ST_DONE : ST_SELECT;
          end
        end

        // Greedy and exact: a 10-coin is only used when at least two steps
        // remain, so a lone step needs a 5-coin or the payout is short.
        ST_SELECT: begin
          if ((r_remaining >= c_STEP_10) && (w_inv_10 != '0)) begin
            r_den_10 <= 1'b1;
            r_state  <= ST_EJECT;
          end else if (w_inv_5 != '0) begin
            r_den_10 <= 1'b0;
            r_state  <= ST_EJECT;
          end else begin
            r_fault_code <= FC_SHORT;
            r_state      <= ST_FAULT;
          end
        end

        ST_EJECT: begin
          r_timer <= '0;
          r_state <= ST_WAIT_ACK;
        end

        // A sensor pulse arriving on the timeout cycle still counts as paid
        ST_WAIT_ACK: begin
          if (i_coin_sensed) begin
            r_remaining <= w_rem_next;
            r_state     <= (w_rem_next == '0) ? ST_DONE : ST_SELECT;
          end else if (r_timer == c_TMR_LAST) begin
            r_fault_code <= FC_JAM;
            r_state      <= ST_FAULT;
          end else begin
            r_timer <= r_timer + c_TMR_W'(1);
          end
        end

        ST_DONE:  r_state <= ST_IDLE;
        ST_FAULT: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_eject_10   = (r_state == ST_EJECT) && r_den_10;
  assign o_eject_5    = (r_state == ST_EJECT) && !r_den_10;
  assign o_done       = (r_state == ST_DONE);
  assign o_fault      = (r_state == ST_FAULT);
  assign o_fault_code = r_fault_code;
  assign o_remaining  = r_remaining;
  assign o_inv_10     = w_inv_10;
  assign o_inv_5      = w_inv_5;

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Payout side of the vending controller. Accepts a change request in 5-unit coin steps and drives the coin hopper, ejecting 10- and 5-value coins one at a time. Each ejection is confirmed by the hopper's coin sensor. Tracks per-denomination coin inventory and reports completion, shortage or jam to the vending FSM.

Parameters:
AMT_W, 8, width of change amount in 5-unit steps (req_units, remaining)
CNT_W, 8, width of each inventory counter
ACK_TIMEOUT, 255, max cycles in WAIT_ACK before jam fault (>=1)
INIT_C10, 0, inventory of 10-coins after reset
INIT_C5, 0, inventory of 5-coins after reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  change request valid
req_units  input  AMT_W  change amount in 5-unit steps (7 = 35)
req_ready  output  1  high only in IDLE
eject_10  output  1  one-cycle pulse: hopper releases one 10-coin
eject_5  output  1  one-cycle pulse: hopper releases one 5-coin
coin_sensed  input  1  hopper sensor pulse: ejected coin has dropped
load_valid  input  1  restock strobe
load_c10  input  CNT_W  10-coins added on load_valid
load_c5  input  CNT_W  5-coins added on load_valid
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: full amount paid
fault  output  1  one-cycle pulse: payout aborted
fault_code  output  2  00 none, 01 insufficient coins, 10 jam/timeout; held until next accepted request
remaining  output  AMT_W  unpaid steps of current/last request
inv_10  output  CNT_W  current 10-coin inventory
inv_5  output  CNT_W  current 5-coin inventory

Behaviour:
- Reset (async): state IDLE. All pulses 0. fault_code=00, remaining=0, timer=0. inv_10=INIT_C10, inv_5=INIT_C5. Reset mid-payout abandons the payout with no done/fault pulse.
- States: IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT.
- IDLE: req_ready=1. On req_valid: latch remaining=req_units, clear fault_code to 00. Next state is DONE if req_units==0, else SELECT.
- SELECT: greedy denomination choice.
  - remaining>=2 and inv_10>0: choose 10.
  - else inv_5>0: choose 5.
  - else: FAULT with code 01.
  - Never overpays. remaining==1 with inv_5==0 gives fault even if inv_10>0.
- EJECT: exactly one of eject_10/eject_5 high for this single cycle. Timer cleared. Next state WAIT_ACK.
- Latency: first eject pulse occurs in the 2nd cycle after the acceptance edge.
- WAIT_ACK: timer increments each cycle.
  - On coin_sensed: remaining -= 2 (10-coin) or 1 (5-coin); chosen inventory -= 1. Next state SELECT if the new remaining != 0, else DONE.
  - If timer reaches ACK_TIMEOUT with no coin_sensed: FAULT with code 10. Inventory and remaining unchanged.
  - coin_sensed and timeout in the same cycle: coin_sensed wins.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: fault=1 for one cycle, then IDLE. remaining holds the unpaid amount until the next accepted request.
- coin_sensed outside WAIT_ACK is ignored.
- req_valid while busy is ignored; no queueing.
- load_valid is accepted in any state. Each counter becomes sat(inv + load - dec), where dec=1 if that counter is decremented in the same cycle. Saturates at 2^CNT_W-1 and never underflows.
- Inventory visible to SELECT is the registered value.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths except none; req_ready is decoded from state.

Decomposition:
- Shared package vending_pkg: state typedef for this block (3-bit enum), fault-code constants FC_NONE/FC_SHORT/FC_JAM, and denomination constants DEN_5=1, DEN_10=2 (in 5-unit steps), shared with the vending FSM.
- One natural sub-module: coin_inventory. It holds the two saturating counters with restock/decrement merge and is instantiated once.

Test Plan:
1. Reset with INIT_C10=5, INIT_C5=5. req_units=7; hopper acks each eject 3 cycles later -> eject_10 x3 then eject_5 x1, done pulse, remaining=0, inv_10=2, inv_5=4, fault never set.
2. inv_10=0, inv_5=3, req_units=4 -> three eject_5, then fault with fault_code=01, remaining=1, inv_5=0.
3. inv_10=4, inv_5=0, req_units=1 -> no eject, fault code 01 two cycles after acceptance, inventory unchanged. Also req_units=0 -> done one cycle after acceptance, no eject.
4. ACK_TIMEOUT=8, req_units=2, coin_sensed never asserted -> one eject_10, fault code 10 after 8 WAIT_ACK cycles, inv_10 and remaining=2 unchanged. Next request clears fault_code.
5. inv_5=CNT max-1, load_valid with load_c5=5 in the same cycle as coin_sensed for a 5-coin -> inv_5 saturates at 255; separately inv_5=3 with load 2 + decrement -> 4.
6. Reset asserted in WAIT_ACK of a 3-coin payout -> immediate IDLE, req_ready=1, no done/fault pulse, inventories at INIT values. A new request then completes normally.
